// File: rtl/jt6295_cmd_ctrl_if.sv
// ROM-table and channel-serializer bus of the MSM6295 command decoder.
// The master side is the decoder; the slave side is the ROM arbiter plus serializer.
interface jt6295_cmd_ctrl_if;
    logic [17:0] start_addr;
    logic [17:0] stop_addr;
    logic [3:0]  att;
    logic [9:0]  rom_addr;
    logic [7:0]  rom_data;
    logic        rom_ok;
    logic        rom_cs;
    logic [3:0]  start;
    logic [3:0]  stop;
    logic [3:0]  busy;
    logic [3:0]  ack;
    logic        zero;

    modport master (
        output start_addr, stop_addr, att, rom_addr, rom_cs, start, stop,
        input  rom_data, rom_ok, busy, ack, zero
    );

    modport slave (
        input  start_addr, stop_addr, att, rom_addr, rom_cs, start, stop,
        output rom_data, rom_ok, busy, ack, zero
    );
endinterface

// File: rtl/jt6295_cmd_ctrl.sv
// MSM6295 CPU command decoder: phrase/stop parsing, phrase-table fetch and channel start.
// Optional macro JT6295_PHRASE_CHECK_EN suppresses phrase 0 and inverted address ranges.
module jt6295_cmd_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen1,
    input  logic       cen4,
    input  logic       wrn,
    input  logic [7:0] din,
    jt6295_cmd_ctrl_if.master bus
);

    typedef enum logic [1:0] {IDLE, WAIT_CH, FETCH, ISSUE} state_t;

    state_t      state;
    state_t      state_next;
    logic        wrn_prev;
    logic [6:0]  phrase;
    logic [3:0]  mask;
    logic [3:0]  att_r;
    logic [2:0]  idx;
    logic        fetch_wait;
    logic        issued;
    logic [3:0]  start_r;
    logic [3:0]  stop_r;
    logic [17:0] start_addr_r;
    logic [17:0] stop_addr_r;

    logic        wr;
    logic        stop_wr;
    logic        capture;
    logic        launch;
    logic [3:0]  launch_mask;
    logic [3:0]  start_next;
    logic [3:0]  stop_next;

    // The channel-select byte is never a stop command, whatever its top bit.
    assign wr       = wrn_prev & ~wrn;
    assign stop_wr  = wr & ~din[7] & (state != WAIT_CH);
    assign capture  = (state == FETCH) & ~fetch_wait & bus.rom_ok;
    assign launch   = (state == ISSUE) & ~issued & cen4 & bus.zero;

`ifdef JT6295_PHRASE_CHECK_EN
    assign launch_mask = ((phrase == 7'd0) || (stop_addr_r < start_addr_r)) ?
                         4'h0 : (mask & ~bus.busy);
`else
    assign launch_mask = mask & ~bus.busy;
`endif

    assign start_next = launch ? launch_mask : (start_r & ~bus.ack);
    assign stop_next  = (cen1 ? (stop_r & bus.busy) : stop_r) | (stop_wr ? din[6:3] : 4'h0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (wr && din[7]) state_next = WAIT_CH;
            WAIT_CH: if (wr) state_next = FETCH;
            FETCH:   if (capture && idx == 3'd5) state_next = ISSUE;
            ISSUE:   if ((launch || issued) && start_next == 4'h0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.rom_cs   = (state == FETCH);
        bus.rom_addr = {phrase, idx};
    end

    assign bus.start      = start_r;
    assign bus.stop       = stop_r;
    assign bus.att        = att_r;
    assign bus.start_addr = start_addr_r;
    assign bus.stop_addr  = stop_addr_r;

    // Each table byte gets one settle cycle after its address before rom_ok is trusted.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrn_prev     <= 1'b1;
            phrase       <= 7'd0;
            mask         <= 4'h0;
            att_r        <= 4'h0;
            idx          <= 3'd0;
            fetch_wait   <= 1'b0;
            issued       <= 1'b0;
            start_r      <= 4'h0;
            stop_r       <= 4'h0;
            start_addr_r <= 18'd0;
            stop_addr_r  <= 18'd0;
        end else begin
            wrn_prev <= wrn;
            start_r  <= start_next;
            stop_r   <= stop_next;
            if (state == IDLE && wr && din[7]) begin
                phrase <= din[6:0];
            end
            if (state == WAIT_CH && wr) begin
                mask       <= din[7:4];
                att_r      <= din[3:0];
                idx        <= 3'd0;
                fetch_wait <= 1'b1;
                issued     <= 1'b0;
            end
            if (state == FETCH) begin
                if (fetch_wait) begin
                    fetch_wait <= 1'b0;
                end else if (bus.rom_ok) begin
                    case (idx)
                        3'd0:    start_addr_r[17:16] <= bus.rom_data[1:0];
                        3'd1:    start_addr_r[15:8]  <= bus.rom_data;
                        3'd2:    start_addr_r[7:0]   <= bus.rom_data;
                        3'd3:    stop_addr_r[17:16]  <= bus.rom_data[1:0];
                        3'd4:    stop_addr_r[15:8]   <= bus.rom_data;
                        3'd5:    stop_addr_r[7:0]    <= bus.rom_data;
                        default: ;
                    endcase
                    if (idx != 3'd5) idx <= idx + 3'd1;
                    fetch_wait <= 1'b1;
                end
            end
            if (launch) issued <= 1'b1;
        end
    end

endmodule

// File: tb/tb_jt6295_cmd_ctrl.sv
// Self-checking bench for jt6295_cmd_ctrl: table-driven phrase plays plus hand-written corner cases.
// Expectations for phrase 0 / inverted ranges follow JT6295_PHRASE_CHECK_EN when defined.
module tb_jt6295_cmd_ctrl;

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  chan;
        logic [3:0]  busy;
        logic [17:0] exp_start_addr;
        logic [17:0] exp_stop_addr;
        logic [3:0]  exp_att;
        logic [3:0]  exp_start;
    } vec_t;

`ifdef JT6295_PHRASE_CHECK_EN
    localparam logic [3:0] EXP_PHRASE0 = 4'h0;
    localparam logic [3:0] EXP_INVERT  = 4'h0;
`else
    localparam logic [3:0] EXP_PHRASE0 = 4'h1;
    localparam logic [3:0] EXP_INVERT  = 4'h8;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cen1;
    logic       cen4;
    logic       wrn;
    logic [7:0] din;
    logic [3:0] busy;
    logic [3:0] ack;
    logic       zero;
    logic       rom_ok;
    logic [7:0] rom [0:1023];

    int checks = 0;
    int errors = 0;

    jt6295_cmd_ctrl_if bus();

    assign bus.busy     = busy;
    assign bus.ack      = ack;
    assign bus.zero     = zero;
    assign bus.rom_ok   = rom_ok;
    assign bus.rom_data = rom_ok ? rom[bus.rom_addr] : 8'h5A;

    jt6295_cmd_ctrl dut (
        .clk  (clk),
        .rst  (rst),
        .cen1 (cen1),
        .cen4 (cen4),
        .wrn  (wrn),
        .din  (din),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic cpuWrite(input logic [7:0] v);
        din = v;
        wrn = 1'b0;
        tick();
        wrn = 1'b1;
        tick();
    endtask

    task automatic pulseCen1();
        cen1 = 1'b1;
        tick();
        cen1 = 1'b0;
    endtask

    task automatic pulseSlot0();
        cen4 = 1'b1;
        zero = 1'b1;
        tick();
        cen4 = 1'b0;
        zero = 1'b0;
    endtask

    task automatic waitFetchDone(input string name);
        int n = 0;
        while (bus.rom_cs && n < 100) begin
            tick();
            n++;
        end
        checkOutput({name, " fetch_done"}, 32'(bus.rom_cs), 32'd0);
    endtask

    task automatic setEntry(input int ph, input logic [47:0] bytes);
        for (int k = 0; k < 6; k++) rom[ph * 8 + k] = bytes[47 - 8 * k -: 8];
    endtask

    // One full phrase play: command, channel byte, fetch, slot-0 launch, per-bit acks.
    task automatic applyStimulus(input vec_t v, input string name);
        logic [3:0] remaining;
        busy = v.busy;
        cpuWrite(v.cmd);
        din = v.chan;
        wrn = 1'b0;
        tick();
        wrn = 1'b1;
        checkOutput({name, " rom_cs_on"}, 32'(bus.rom_cs), 32'd1);
        waitFetchDone(name);
        checkOutput({name, " start_addr"}, 32'(bus.start_addr), 32'(v.exp_start_addr));
        checkOutput({name, " stop_addr"}, 32'(bus.stop_addr), 32'(v.exp_stop_addr));
        checkOutput({name, " att"}, 32'(bus.att), 32'(v.exp_att));
        cen4 = 1'b1;
        tick();
        cen4 = 1'b0;
        checkOutput({name, " no_launch_off_slot0"}, 32'(bus.start), 32'd0);
        pulseSlot0();
        checkOutput({name, " start"}, 32'(bus.start), 32'(v.exp_start));
        remaining = v.exp_start;
        for (int b = 0; b < 4; b++) begin
            if (v.exp_start[b]) begin
                ack = 4'(1 << b);
                tick();
                ack = 4'h0;
                remaining[b] = 1'b0;
                checkOutput({name, " start_after_ack"}, 32'(bus.start), 32'(remaining));
            end
        end
        busy = 4'h0;
    endtask

    initial begin
        vec_t vecs[7];
        int   exp_idx;
        bit   seq_ok;
        bit   stall_ok;
        bit   stalled;
        logic [9:0] held;

        for (int i = 0; i < 1024; i++) rom[i] = 8'(i ^ 8'hA5);
        setEntry(0,   48'h00_00_10_00_00_20);
        setEntry(1,   48'h01_23_45_02_00_10);
        setEntry(2,   48'h03_00_00_01_00_00);
        setEntry(3,   48'hFD_11_22_FE_33_44);
        setEntry(5,   48'h02_AB_CD_03_12_34);
        setEntry(127, 48'h03_FF_FF_03_FF_FF);

        vecs[0] = '{8'h81, 8'h23, 4'h0, 18'h12345, 18'h20010, 4'h3, 4'h2};
        vecs[1] = '{8'h85, 8'hF0, 4'h2, 18'h2ABCD, 18'h31234, 4'h0, 4'hD};
        vecs[2] = '{8'h83, 8'h4A, 4'h0, 18'h11122, 18'h23344, 4'hA, 4'h4};
        vecs[3] = '{8'hFF, 8'h1F, 4'h0, 18'h3FFFF, 18'h3FFFF, 4'hF, 4'h1};
        vecs[4] = '{8'h80, 8'h10, 4'h0, 18'h00010, 18'h00020, 4'h0, EXP_PHRASE0};
        vecs[5] = '{8'h82, 8'h8C, 4'h0, 18'h30000, 18'h10000, 4'hC, EXP_INVERT};
        vecs[6] = '{8'h81, 8'h35, 4'h3, 18'h12345, 18'h20010, 4'h5, 4'h0};

        rst = 1'b1; cen1 = 1'b0; cen4 = 1'b0; wrn = 1'b1; din = 8'h00;
        busy = 4'h0; ack = 4'h0; zero = 1'b0; rom_ok = 1'b1;
        repeat (3) tick();
        checkOutput("reset start", 32'(bus.start), 32'd0);
        checkOutput("reset stop", 32'(bus.stop), 32'd0);
        checkOutput("reset rom_cs", 32'(bus.rom_cs), 32'd0);
        checkOutput("reset rom_addr", 32'(bus.rom_addr), 32'd0);
        checkOutput("reset addrs", {bus.start_addr[13:0], bus.stop_addr}, 32'd0);
        checkOutput("reset att", 32'(bus.att), 32'd0);
        rst = 1'b0;
        tick();

        cpuWrite(8'h78);
        checkOutput("stop all set", 32'(bus.stop), 32'hF);
        pulseCen1();
        checkOutput("stop all cleared", 32'(bus.stop), 32'h0);
        busy = 4'h4;
        cpuWrite(8'h20);
        checkOutput("stop ch2 set", 32'(bus.stop), 32'h4);
        pulseCen1();
        checkOutput("stop ch2 held busy", 32'(bus.stop), 32'h4);
        busy = 4'h0;
        pulseCen1();
        checkOutput("stop ch2 cleared", 32'(bus.stop), 32'h0);

        for (int i = 0; i < 7; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // Address stepping with a 10-cycle rom_ok stall at byte 2.
        cpuWrite(8'h81);
        cpuWrite(8'h23);
        exp_idx = 0; seq_ok = 1'b1; stall_ok = 1'b1; stalled = 1'b0;
        for (int c = 0; c < 200 && bus.rom_cs; c++) begin
            if (bus.rom_addr == 10'(9 + exp_idx)) exp_idx++;
            else if (bus.rom_addr != 10'(8 + exp_idx)) seq_ok = 1'b0;
            if (exp_idx == 2 && !stalled) begin
                stalled = 1'b1;
                rom_ok = 1'b0;
                held = bus.rom_addr;
                repeat (10) begin
                    tick();
                    if (bus.rom_addr !== held || bus.rom_cs !== 1'b1) stall_ok = 1'b0;
                end
                rom_ok = 1'b1;
            end
            tick();
        end
        checkOutput("stall rom_addr seq", 32'(seq_ok), 32'd1);
        checkOutput("stall last idx", 32'(exp_idx), 32'd5);
        checkOutput("stall held", 32'(stall_ok), 32'd1);
        checkOutput("stall rom_cs off", 32'(bus.rom_cs), 32'd0);
        checkOutput("stall start_addr", 32'(bus.start_addr), 32'h12345);
        checkOutput("stall stop_addr", 32'(bus.stop_addr), 32'h20010);
        pulseSlot0();
        checkOutput("stall start", 32'(bus.start), 32'h2);

        // Ack and stop land on channel 1 in the same cycle.
        busy = 4'h2;
        din = 8'h10; wrn = 1'b0; ack = 4'h2;
        tick();
        wrn = 1'b1; ack = 4'h0;
        tick();
        checkOutput("ack+stop start", 32'(bus.start), 32'h0);
        checkOutput("ack+stop stop", 32'(bus.stop), 32'h2);
        pulseCen1();
        checkOutput("ack+stop stop busy", 32'(bus.stop), 32'h2);
        busy = 4'h0;
        pulseCen1();
        checkOutput("ack+stop stop clear", 32'(bus.stop), 32'h0);

        // Phrase command ignored during FETCH and ISSUE; stop honoured.
        cpuWrite(8'h81);
        cpuWrite(8'h23);
        cpuWrite(8'h90);
        cpuWrite(8'h40);
        checkOutput("ignore stop ch3", 32'(bus.stop), 32'h8);
        checkOutput("ignore fetch continues", 32'(bus.rom_cs), 32'd1);
        waitFetchDone("ignore");
        checkOutput("ignore att", 32'(bus.att), 32'h3);
        checkOutput("ignore start_addr", 32'(bus.start_addr), 32'h12345);
        cpuWrite(8'h90);
        pulseSlot0();
        checkOutput("ignore start", 32'(bus.start), 32'h2);
        checkOutput("ignore att issue", 32'(bus.att), 32'h3);
        ack = 4'h2;
        tick();
        ack = 4'h0;
        checkOutput("ignore start cleared", 32'(bus.start), 32'h0);
        pulseCen1();
        checkOutput("ignore stop cleared", 32'(bus.stop), 32'h0);

        // Reset in the middle of a fetch.
        cpuWrite(8'h81);
        cpuWrite(8'h23);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        checkOutput("midreset rom_cs", 32'(bus.rom_cs), 32'd0);
        checkOutput("midreset rom_addr", 32'(bus.rom_addr), 32'd0);
        checkOutput("midreset start_addr", 32'(bus.start_addr), 32'd0);
        checkOutput("midreset att", 32'(bus.att), 32'd0);
        rst = 1'b0;
        tick();
        applyStimulus(vecs[1], "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
